matcher_seq_ctrl: RTL and testbench
===================================

MATCHER_SEQ_CTRL -- requirements
Module: matcher_seq_ctrl

Interface
REQ-001 SHALL have parameter INPUT_STREAM_WIDTH, default 512, width of one stream beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, width of matcher result data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2048, maximum cycles to wait for a matcher result.
REQ-004 Ports, as name / direction / width / meaning:
- fclk / in / 1 / clock, all logic on rising edge.
- areset_n / in / 1 / synchronous, active-low reset.
- s_data / in / INPUT_STREAM_WIDTH / input beat.
- s_valid / in / 1 / input beat valid.
- s_ready / out / 1 / controller accepts beat.
- s_last / in / 1 / final beat of packet.
- mt_input_stream / out / INPUT_STREAM_WIDTH / beat to matcher.
- mt_data_valid / out / 1 / one-cycle beat strobe to matcher.
- mt_result_valid / in / 1 / matcher result ready.
- mt_result_match / in / 1 / matcher hit.
- mt_result_data / in / DATA_WIDTH / matched pattern.
- mt_result_reset / out / 1 / one-cycle matcher result clear.
- m_valid / out / 1 / report valid.
- m_ready / in / 1 / report consumer ready.
- m_data / out / DATA_WIDTH / matched pattern.
- m_beat_idx / out / 16 / beat index within packet.
- m_last / out / 1 / report belongs to last beat.
- match_count / out / 32 / total hits since reset or clear.
- beat_count / out / 32 / total beats processed.
- timeout_err / out / 1 / sticky timeout flag.
- busy / out / 1 / FSM not in IDLE.
- clear_stats / in / 1 / clears counters and timeout_err.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, WAIT, REPORT, CLEAR.
REQ-006 IDLE: s_ready=1; on s_valid&&s_ready SHALL latch s_data, s_last and the beat index into holding registers, then go to LOAD.
REQ-007 LOAD: mt_data_valid=1 for exactly one cycle and mt_input_stream=held beat; next state WAIT.
REQ-008 mt_input_stream SHALL hold the latched beat unchanged from LOAD until the following acceptance.
REQ-009 WAIT: timeout counter increments each cycle. On mt_result_valid&&mt_result_match SHALL latch mt_result_data and go to REPORT. On mt_result_valid&&!mt_result_match SHALL go to CLEAR.
REQ-010 WAIT: if the counter reaches TIMEOUT_CYCLES-1 without mt_result_valid, SHALL set timeout_err and go to CLEAR. If mt_result_valid arrives on that same cycle, the result wins and no timeout is flagged.
REQ-011 REPORT: m_valid=1 with m_data, m_beat_idx and m_last stable until m_ready; the transfer on m_valid&&m_ready SHALL go to CLEAR. No report is produced for a non-match.
REQ-012 CLEAR: mt_result_reset=1 for exactly one cycle; next state IDLE.
REQ-013 s_ready SHALL be 1 only in IDLE, so one beat is in flight and the controller adds 2 cycles of overhead beyond matcher latency plus the report stall.
REQ-014 Beat index SHALL increment per accepted beat, reset to 0 after a beat with s_last=1, and wrap 0xFFFF->0.
REQ-015 beat_count SHALL increment on leaving CLEAR; match_count SHALL increment on a REPORT transfer. Both wrap modulo 2^32.
REQ-016 clear_stats SHALL zero match_count, beat_count and timeout_err; if an increment occurs on the same cycle, clear wins.
REQ-017 busy SHALL be 1 in every state except IDLE.

Reset
REQ-018 With areset_n=0 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-WAIT or mid-REPORT.
REQ-019 Reset values: s_ready=0 during reset and 1 after release; mt_data_valid=0; mt_result_reset=0; m_valid=0; m_data=0; m_beat_idx=0; m_last=0; mt_input_stream=0; match_count=0; beat_count=0; timeout_err=0; busy=0.

Verification
REQ-020 Single beat, result_valid+match with data 0xDEAD_BEEF after 10 cycles -> exactly one mt_data_valid pulse, m_valid with m_data=0xDEADBEEF and m_beat_idx=0, one mt_result_reset pulse, match_count=1.
REQ-021 Three-beat packet, only beat 1 matches, m_ready held low 5 cycles -> one report with m_beat_idx=1 and m_last=0, report fields stable during the stall, beat_count=3, next packet starts at index 0.
REQ-022 No mt_result_valid with TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles, one mt_result_reset pulse, return to IDLE.
REQ-023 mt_result_valid on the final timeout cycle -> timeout_err remains 0.
REQ-024 areset_n asserted during REPORT -> m_valid=0 and busy=0 after the edge, counters 0; the next beat is processed normally.
REQ-025 clear_stats on the same cycle as a match transfer -> match_count=0.

Source files
------------

// File: rtl/matcher_seq_ctrl_if.sv
// Signal bundle between the sequencing controller, the beat source, the
// pattern matcher and the report consumer.
interface matcher_seq_ctrl_if #(
    parameter int INPUT_STREAM_WIDTH = 512,
    parameter int DATA_WIDTH         = 64
);
    // s_* and m_* channels: a transfer happens on a rising edge where valid
    // and ready are both high; once valid rises its payload stays stable and
    // valid stays high until that transfer, and ready never waits on valid.
    logic [INPUT_STREAM_WIDTH-1:0] s_data;
    logic                          s_valid;
    logic                          s_ready;
    logic                          s_last;

    logic [INPUT_STREAM_WIDTH-1:0] mt_input_stream;
    logic                          mt_data_valid;
    logic                          mt_result_valid;
    logic                          mt_result_match;
    logic [DATA_WIDTH-1:0]         mt_result_data;
    logic                          mt_result_reset;

    logic                          m_valid;
    logic                          m_ready;
    logic [DATA_WIDTH-1:0]         m_data;
    logic [15:0]                   m_beat_idx;
    logic                          m_last;

    modport master (
        input  s_data, s_valid, s_last,
        output s_ready,
        output mt_input_stream, mt_data_valid, mt_result_reset,
        input  mt_result_valid, mt_result_match, mt_result_data,
        output m_valid, m_data, m_beat_idx, m_last,
        input  m_ready
    );

    modport slave (
        output s_data, s_valid, s_last,
        input  s_ready,
        input  mt_input_stream, mt_data_valid, mt_result_reset,
        output mt_result_valid, mt_result_match, mt_result_data,
        input  m_valid, m_data, m_beat_idx, m_last,
        output m_ready
    );
endinterface

// File: rtl/matcher_seq_ctrl.sv
// Feeds one stream beat at a time to a pattern matcher, waits (bounded) for
// its verdict, reports hits downstream and keeps hit/beat statistics.
module matcher_seq_ctrl #(
    parameter int INPUT_STREAM_WIDTH = 512,
    parameter int DATA_WIDTH         = 64,
    parameter int TIMEOUT_CYCLES     = 2048
) (
    input  logic                 fclk,
    input  logic                 areset_n,
    matcher_seq_ctrl_if.master   bus,
    input  logic                 clear_stats,
    output logic [31:0]          match_count,
    output logic [31:0]          beat_count,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [2:0]           fsm_state
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPORT = 3'd3,
        ST_CLEAR  = 3'd4
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [INPUT_STREAM_WIDTH-1:0] hold_beat;
    logic                          hold_last;
    logic [15:0]                   hold_idx;
    logic [15:0]                   next_idx;
    logic [DATA_WIDTH-1:0]         res_data;
    logic [TW-1:0]                 to_cnt;
    logic                          accept;
    logic                          to_expire;
    logic                          report_xfer;

    assign accept      = bus.s_valid && bus.s_ready;
    // A result arriving on the last allowed cycle takes priority over expiry.
    assign to_expire   = (state == ST_WAIT) && !bus.mt_result_valid && (to_cnt == TO_LAST);
    assign report_xfer = (state == ST_REPORT) && bus.m_ready;

    always_ff @(posedge fclk) begin
        if (!areset_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.s_valid) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.mt_result_valid) state_nxt = bus.mt_result_match ? ST_REPORT : ST_CLEAR;
                else if (to_expire)      state_nxt = ST_CLEAR;
            end
            ST_REPORT: if (bus.m_ready) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready         = 1'b0;
        bus.mt_data_valid   = 1'b0;
        bus.mt_result_reset = 1'b0;
        bus.m_valid         = 1'b0;
        busy                = 1'b1;
        case (state)
            ST_IDLE: begin
                bus.s_ready = areset_n;
                busy        = 1'b0;
            end
            ST_LOAD:   bus.mt_data_valid   = 1'b1;
            ST_REPORT: bus.m_valid         = 1'b1;
            ST_CLEAR:  bus.mt_result_reset = 1'b1;
            default: ;
        endcase
    end

    // Holding registers double as the outward-facing beat and report fields.
    always_ff @(posedge fclk) begin
        if (!areset_n) begin
            hold_beat   <= '0;
            hold_last   <= 1'b0;
            hold_idx    <= '0;
            next_idx    <= '0;
            res_data    <= '0;
            to_cnt      <= '0;
            match_count <= '0;
            beat_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                hold_beat <= bus.s_data;
                hold_last <= bus.s_last;
                hold_idx  <= next_idx;
                next_idx  <= bus.s_last ? 16'd0 : next_idx + 16'd1;
            end

            if (state != ST_WAIT)          to_cnt <= '0;
            else if (!bus.mt_result_valid) to_cnt <= to_cnt + 1'b1;

            if ((state == ST_WAIT) && bus.mt_result_valid && bus.mt_result_match)
                res_data <= bus.mt_result_data;

            if (clear_stats) begin
                match_count <= '0;
                beat_count  <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (report_xfer)        match_count <= match_count + 32'd1;
                if (state == ST_CLEAR)  beat_count  <= beat_count + 32'd1;
                if (to_expire)          timeout_err <= 1'b1;
            end
        end
    end

    assign bus.mt_input_stream = hold_beat;
    assign bus.m_data          = res_data;
    assign bus.m_beat_idx      = hold_idx;
    assign bus.m_last          = hold_last;
    assign fsm_state           = state;
endmodule

// File: tb/tb_matcher_seq_ctrl.sv
// Directed bench for matcher_seq_ctrl: drives beats and matcher verdicts by
// hand and checks strobes, reports, counters, timeout and reset behaviour.
module tb_matcher_seq_ctrl;
    localparam int ISW = 64;
    localparam int DW  = 64;
    localparam int TO  = 16;
    localparam int W   = 16 + 1 + DW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;

    logic        fclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        clear_stats = 1'b0;
    logic [31:0] match_count;
    logic [31:0] beat_count;
    logic        timeout_err;
    logic        busy;
    logic [2:0]  fsm_state;

    int total = 0;
    int bad = 0;
    int dv_pulses = 0;
    int rr_pulses = 0;
    int dv_base;
    int rr_base;
    logic [W-1:0] exp_q[$];

    matcher_seq_ctrl_if #(.INPUT_STREAM_WIDTH(ISW), .DATA_WIDTH(DW)) bus ();

    matcher_seq_ctrl #(
        .INPUT_STREAM_WIDTH(ISW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .fclk(fclk),
        .areset_n(areset_n),
        .bus(bus),
        .clear_stats(clear_stats),
        .match_count(match_count),
        .beat_count(beat_count),
        .timeout_err(timeout_err),
        .busy(busy),
        .fsm_state(fsm_state)
    );

    // clock / watchdog
    always #5 fclk = ~fclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe counters and report scoreboard
    always @(posedge fclk) begin
        if (bus.mt_data_valid === 1'b1)   dv_pulses++;
        if (bus.mt_result_reset === 1'b1) rr_pulses++;
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_report", {bus.m_beat_idx, bus.m_last, bus.m_data}, '0);
            end else begin
                check("report", {bus.m_beat_idx, bus.m_last, bus.m_data}, exp_q.pop_front());
            end
        end
    end

    // driver tasks (entered and left just after a falling edge)
    task automatic send_beat(input logic [ISW-1:0] d, input logic l);
        int n = 0;
        while (bus.s_ready !== 1'b1 && n < 50) begin
            @(negedge fclk);
            n++;
        end
        check("accept_wait", W'(n < 50), W'(1));
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        @(negedge fclk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic do_result(input int wait_cyc, input logic match, input logic [DW-1:0] data);
        repeat (wait_cyc) @(negedge fclk);
        bus.mt_result_valid = 1'b1;
        bus.mt_result_match = match;
        bus.mt_result_data  = data;
        @(negedge fclk);
        bus.mt_result_valid = 1'b0;
        bus.mt_result_match = 1'b0;
        bus.mt_result_data  = '0;
    endtask

    initial begin
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        bus.mt_result_valid = 1'b0;
        bus.mt_result_match = 1'b0;
        bus.mt_result_data = '0;
        bus.m_ready = 1'b1;

        // reset state
        repeat (3) @(negedge fclk);
        check("rst_s_ready", W'(bus.s_ready), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_state", W'(fsm_state), W'(S_IDLE));
        check("rst_m_fields", {bus.m_beat_idx, bus.m_last, bus.m_data}, '0);
        check("rst_strobes", W'({bus.mt_data_valid, bus.mt_result_reset, bus.m_valid}), W'(0));
        check("rst_counters", W'({match_count, beat_count, timeout_err}), W'(0));
        check("rst_stream", W'(bus.mt_input_stream), W'(0));
        areset_n = 1'b1;
        @(negedge fclk);
        check("rel_s_ready", W'(bus.s_ready), W'(1));

        // single beat, match after 10 cycles
        dv_base = dv_pulses;
        rr_base = rr_pulses;
        exp_q.push_back({16'd0, 1'b1, 64'hDEAD_BEEF});
        send_beat(64'hCAFE_0001, 1'b1);
        check("load_dv", W'(bus.mt_data_valid), W'(1));
        check("load_stream", W'(bus.mt_input_stream), W'(64'hCAFE_0001));
        check("load_state", W'(fsm_state), W'(S_LOAD));
        do_result(10, 1'b1, 64'hDEAD_BEEF);
        check("t1_m_valid", W'(bus.m_valid), W'(1));
        check("t1_m_fields", {bus.m_beat_idx, bus.m_last, bus.m_data}, {16'd0, 1'b1, 64'hDEAD_BEEF});
        @(negedge fclk);
        check("t1_clear_rr", W'(bus.mt_result_reset), W'(1));
        check("t1_match_count", W'(match_count), W'(1));
        check("t1_stream_hold", W'(bus.mt_input_stream), W'(64'hCAFE_0001));
        @(negedge fclk);
        check("t1_beat_count", W'(beat_count), W'(1));
        check("t1_dv_pulses", W'(dv_pulses - dv_base), W'(1));
        check("t1_rr_pulses", W'(rr_pulses - rr_base), W'(1));
        check("t1_idle", W'({busy, bus.s_ready}), W'(2'b01));

        // three-beat packet, only beat 1 matches, report stalled 5 cycles
        send_beat(64'hA0, 1'b0);
        do_result(2, 1'b0, 64'h0);
        check("t2_nomatch_no_report", W'(bus.m_valid), W'(0));
        check("t2_nomatch_rr", W'(bus.mt_result_reset), W'(1));
        @(negedge fclk);
        exp_q.push_back({16'd1, 1'b0, 64'h1111});
        bus.m_ready = 1'b0;
        send_beat(64'hA1, 1'b0);
        do_result(3, 1'b1, 64'h1111);
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", W'(bus.m_valid), W'(1));
            check("t2_stall_fields", {bus.m_beat_idx, bus.m_last, bus.m_data}, {16'd1, 1'b0, 64'h1111});
            @(negedge fclk);
        end
        bus.m_ready = 1'b1;
        @(negedge fclk);
        @(negedge fclk);
        send_beat(64'hA2, 1'b1);
        do_result(1, 1'b0, 64'h0);
        @(negedge fclk);
        check("t2_beat_count", W'(beat_count), W'(4));
        check("t2_match_count", W'(match_count), W'(2));
        exp_q.push_back({16'd0, 1'b1, 64'h2222});
        send_beat(64'hB0, 1'b1);
        do_result(4, 1'b1, 64'h2222);
        check("t2_next_pkt_idx", W'(bus.m_beat_idx), W'(0));
        @(negedge fclk);
        @(negedge fclk);
        check("t2_counts", W'({match_count, beat_count}), W'({32'd3, 32'd5}));

        // timeout with no result
        rr_base = rr_pulses;
        send_beat(64'hC0, 1'b1);
        repeat (TO) @(negedge fclk);
        check("t3_last_wait_state", W'(fsm_state), W'(S_WAIT));
        check("t3_no_err_yet", W'(timeout_err), W'(0));
        @(negedge fclk);
        check("t3_timeout_err", W'(timeout_err), W'(1));
        check("t3_clear_state", W'(fsm_state), W'(S_CLEAR));
        @(negedge fclk);
        check("t3_idle", W'({busy, bus.s_ready}), W'(2'b01));
        check("t3_rr_pulses", W'(rr_pulses - rr_base), W'(1));
        check("t3_beat_count", W'(beat_count), W'(6));

        clear_stats = 1'b1;
        @(negedge fclk);
        clear_stats = 1'b0;
        check("clr_stats", W'({match_count, beat_count, timeout_err}), W'(0));

        // result on the final timeout cycle wins
        send_beat(64'hC1, 1'b1);
        do_result(TO, 1'b0, 64'h0);
        check("t4_clear_state", W'(fsm_state), W'(S_CLEAR));
        check("t4_no_timeout", W'(timeout_err), W'(0));
        @(negedge fclk);
        check("t4_beat_count", W'(beat_count), W'(1));

        // clear_stats coincident with a report transfer
        exp_q.push_back({16'd0, 1'b1, 64'h3333});
        bus.m_ready = 1'b0;
        send_beat(64'hD0, 1'b1);
        do_result(2, 1'b1, 64'h3333);
        check("t5_report_state", W'(fsm_state), W'(S_REPORT));
        bus.m_ready = 1'b1;
        clear_stats = 1'b1;
        @(negedge fclk);
        clear_stats = 1'b0;
        check("t5_match_cleared", W'(match_count), W'(0));
        @(negedge fclk);
        check("t5_after", W'({match_count, beat_count}), W'({32'd0, 32'd1}));

        // reset during REPORT
        bus.m_ready = 1'b0;
        send_beat(64'hE0, 1'b0);
        do_result(2, 1'b1, 64'h4444);
        check("t6_in_report", W'(bus.m_valid), W'(1));
        areset_n = 1'b0;
        @(negedge fclk);
        check("t6_rst_valid_busy", W'({bus.m_valid, busy, bus.s_ready}), W'(0));
        check("t6_rst_state", W'(fsm_state), W'(S_IDLE));
        check("t6_rst_counters", W'({match_count, beat_count}), W'(0));
        check("t6_rst_fields", {bus.m_beat_idx, bus.m_last, bus.m_data}, '0);
        areset_n = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge fclk);
        check("t6_rel_s_ready", W'(bus.s_ready), W'(1));
        exp_q.push_back({16'd0, 1'b1, 64'h5555});
        send_beat(64'hF0, 1'b1);
        check("t6_load_stream", W'(bus.mt_input_stream), W'(64'hF0));
        do_result(3, 1'b1, 64'h5555);
        check("t6_report_data", W'(bus.m_data), W'(64'h5555));
        @(negedge fclk);
        @(negedge fclk);
        check("t6_counts", W'({match_count, beat_count}), W'({32'd1, 32'd1}));

        // final report
        check("sb_drained", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
